// File: rtl/bram_tdp_1ck_be.sv
// Single-clock true dual-port RAM with byte-lane write enables.
// Handshake: a port issues an operation on any rising edge where enX=1;
// its read result appears READ_LAT edges later as doutX with a one-cycle
// vldX strobe. There is no back-pressure, and doutX holds while vldX=0.
// A same-cycle, same-address access by the other port sees write-first data.
module bram_tdp_1ck_be #(
  parameter int    WIDTH     = 64,
  parameter int    BYTE_W    = 8,
  parameter int    DEPTH     = 512,
  parameter int    READ_LAT  = 1,
  parameter string WR_MODE   = "WRITE_FIRST",
  parameter string PRIORITY  = "A",
  parameter int    INIT_ZERO = 1,
  parameter int    CNT_W     = 16,
  localparam int   NB        = WIDTH / BYTE_W,
  localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clka,
  input  logic             rstb,
  input  logic             ena,
  input  logic [NB-1:0]    wea,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dina,
  output logic [WIDTH-1:0] douta,
  output logic             vlda,
  input  logic             enb,
  input  logic [NB-1:0]    web,
  input  logic [AW-1:0]    addrb,
  input  logic [WIDTH-1:0] dinb,
  output logic [WIDTH-1:0] doutb,
  output logic             vldb,
  output logic             coll_flag,
  output logic [CNT_W-1:0] coll_cnt
);

  localparam bit MODE_RF = (WR_MODE == "READ_FIRST");
  localparam bit MODE_NC = (WR_MODE == "NO_CHANGE");
  localparam bit PRIO_B  = (PRIORITY == "B");
  localparam bit POW2    = (DEPTH == (1 << AW));
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  // Declaration-time fill only; reset never touches the array.
  logic [WIDTH-1:0] mem_q [DEPTH] =
    '{default: (INIT_ZERO != 0) ? {WIDTH{1'b0}} : {WIDTH{1'bx}}};

  logic             a_in, b_in, a_wr, b_wr, same_addr, coll;
  logic [WIDTH-1:0] a_old, b_old, a_new, b_new;
  logic [1:0]             iss;
  logic [1:0][WIDTH-1:0]  iss_dat;
  logic [1:0]             st_vld;
  logic [1:0][WIDTH-1:0]  st_dat;
  logic [1:0]             vld_q;
  logic [1:0][WIDTH-1:0]  dout_q;
  logic                   coll_flag_q;
  logic [CNT_W-1:0]       coll_cnt_q, coll_cnt_d;

  // Resolve the post-write word seen at each port's address, lane by lane.
  always_comb begin
    a_in      = POW2 ? 1'b1 : ({1'b0, addra} < DEPTH_L);
    b_in      = POW2 ? 1'b1 : ({1'b0, addrb} < DEPTH_L);
    a_wr      = ena & (|wea);
    b_wr      = enb & (|web);
    same_addr = ena & enb & (addra == addrb);
    coll      = same_addr & (|(wea & web));
    a_old     = a_in ? mem_q[addra] : '0;
    b_old     = b_in ? mem_q[addrb] : '0;
    a_new     = a_old;
    b_new     = b_old;
    for (int i = 0; i < NB; i++) begin
      if (same_addr & wea[i] & web[i]) begin
        a_new[i*BYTE_W +: BYTE_W] = PRIO_B ? dinb[i*BYTE_W +: BYTE_W] : dina[i*BYTE_W +: BYTE_W];
        b_new[i*BYTE_W +: BYTE_W] = PRIO_B ? dinb[i*BYTE_W +: BYTE_W] : dina[i*BYTE_W +: BYTE_W];
      end else begin
        if (ena & wea[i])                  a_new[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
        else if (same_addr & web[i])       a_new[i*BYTE_W +: BYTE_W] = dinb[i*BYTE_W +: BYTE_W];
        if (enb & web[i])                  b_new[i*BYTE_W +: BYTE_W] = dinb[i*BYTE_W +: BYTE_W];
        else if (same_addr & wea[i])       b_new[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
      end
    end
    if (!a_in) a_new = '0;
    if (!b_in) b_new = '0;
    // Own-port return: plain reads and WRITE_FIRST give the resolved word.
    iss[0]     = ena & ~(a_wr & MODE_NC);
    iss[1]     = enb & ~(b_wr & MODE_NC);
    iss_dat[0] = (a_wr & MODE_RF) ? a_old : a_new;
    iss_dat[1] = (b_wr & MODE_RF) ? b_old : b_new;
    coll_cnt_d = coll_cnt_q;
    if (coll && (coll_cnt_q != {CNT_W{1'b1}})) coll_cnt_d = coll_cnt_q + 1'b1;
  end

  // Array update; in-range writes only, both ports may write in one cycle.
  always_ff @(posedge clka) begin
    if (a_wr & a_in) mem_q[addra] <= a_new;
    if (b_wr & b_in) mem_q[addrb] <= b_new;
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [1:0]            p1_vld_q;
      logic [1:0][WIDTH-1:0] p1_dat_q;
      // First read stage; advances every cycle and is cleared by reset.
      always_ff @(posedge clka) begin
        if (rstb) begin
          p1_vld_q <= '0;
          p1_dat_q <= '0;
        end else begin
          p1_vld_q <= iss;
          p1_dat_q <= iss_dat;
        end
      end
      assign st_vld = p1_vld_q;
      assign st_dat = p1_dat_q;
    end else begin : g_lat1
      assign st_vld = iss;
      assign st_dat = iss_dat;
    end
  endgenerate

  // Output register: capture only valid results so dout holds otherwise.
  always_ff @(posedge clka) begin
    if (rstb) begin
      vld_q  <= '0;
      dout_q <= '0;
    end else begin
      vld_q <= st_vld;
      for (int p = 0; p < 2; p++) begin
        if (st_vld[p]) dout_q[p] <= st_dat[p];
      end
    end
  end

  // Collision pulse and saturating counter.
  always_ff @(posedge clka) begin
    if (rstb) begin
      coll_flag_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      coll_flag_q <= coll;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign douta     = dout_q[0];
  assign doutb     = dout_q[1];
  assign vlda      = vld_q[0];
  assign vldb      = vld_q[1];
  assign coll_flag = coll_flag_q;
  assign coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_bram_tdp_1ck_be.sv
// Bench for bram_tdp_1ck_be: three configurations share one stimulus stream.
// d0: DEPTH16 LAT1 WRITE_FIRST PRIORITY A CNT_W2
// d1: DEPTH16 LAT2 READ_FIRST  PRIORITY B CNT_W16
// d2: DEPTH12 LAT1 NO_CHANGE   PRIORITY A CNT_W16 (addresses 12..15 out of range)
module tb_bram_tdp_1ck_be;

  logic        clka = 1'b0;
  logic        rstb = 1'b1;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0, web = '0;
  logic [3:0]  addra = '0, addrb = '0;
  logic [31:0] dina = '0, dinb = '0;

  wire [31:0] d_dout [3][2];
  wire        d_vld  [3][2];
  wire        d_flag [3];
  wire [1:0]  cnt0;
  wire [15:0] cnt1, cnt2;

  int n_chk = 0;
  int n_err = 0;

  // Clock
  always #5 clka = ~clka;

  bram_tdp_1ck_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(16), .READ_LAT(1), .WR_MODE("WRITE_FIRST"),
    .PRIORITY("A"), .INIT_ZERO(1), .CNT_W(2)) u_d0 (
    .clka(clka), .rstb(rstb),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(d_dout[0][0]), .vlda(d_vld[0][0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(d_dout[0][1]), .vldb(d_vld[0][1]),
    .coll_flag(d_flag[0]), .coll_cnt(cnt0));

  bram_tdp_1ck_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(16), .READ_LAT(2), .WR_MODE("READ_FIRST"),
    .PRIORITY("B"), .INIT_ZERO(1), .CNT_W(16)) u_d1 (
    .clka(clka), .rstb(rstb),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(d_dout[1][0]), .vlda(d_vld[1][0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(d_dout[1][1]), .vldb(d_vld[1][1]),
    .coll_flag(d_flag[1]), .coll_cnt(cnt1));

  bram_tdp_1ck_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(12), .READ_LAT(1), .WR_MODE("NO_CHANGE"),
    .PRIORITY("A"), .INIT_ZERO(1), .CNT_W(16)) u_d2 (
    .clka(clka), .rstb(rstb),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(d_dout[2][0]), .vlda(d_vld[2][0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(d_dout[2][1]), .vldb(d_vld[2][1]),
    .coll_flag(d_flag[2]), .coll_cnt(cnt2));

  // ---------------- behavioural model ----------------
  int cfg_lat   [3] = '{1, 2, 1};
  int cfg_mode  [3] = '{0, 1, 2};          // 0 write-first, 1 read-first, 2 no-change
  int cfg_prio  [3] = '{0, 1, 0};          // 0 A wins, 1 B wins
  int cfg_depth [3] = '{16, 16, 12};
  int cfg_cmax  [3] = '{3, 65535, 65535};

  logic [31:0] m_mem  [3][16];
  bit          s_vld  [3][2][512];
  logic [31:0] s_dat  [3][2][512];
  logic [31:0] e_dout [3][2];
  bit          e_vld  [3][2];
  bit          e_flag [3];
  int          e_cnt  [3];
  int          cyc = 0;
  bit          model_ok = 0;

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 16; a++) m_mem[d][a] = '0;
      for (int p = 0; p < 2; p++) begin
        e_dout[d][p] = '0;
        e_vld[d][p]  = 0;
        for (int c = 0; c < 512; c++) s_vld[d][p][c] = 0;
      end
      e_flag[d] = 0;
      e_cnt[d]  = 0;
    end
  end

  // Word visible at address 'ad' once this edge's writes from both ports land.
  function automatic logic [31:0] post_word(int d, logic [3:0] ad);
    logic [31:0] w;
    bit hit_a, hit_b, la, lb;
    if (ad >= cfg_depth[d]) return 32'h0;
    w = m_mem[d][ad];
    hit_a = ena && (addra == ad);
    hit_b = enb && (addrb == ad);
    for (int i = 0; i < 4; i++) begin
      la = hit_a && wea[i];
      lb = hit_b && web[i];
      if (la && lb)  w[8*i +: 8] = (cfg_prio[d] == 1) ? dinb[8*i +: 8] : dina[8*i +: 8];
      else if (la)   w[8*i +: 8] = dina[8*i +: 8];
      else if (lb)   w[8*i +: 8] = dinb[8*i +: 8];
    end
    return w;
  endfunction

  task automatic model_edge(int d);
    logic [31:0] pre [2];
    logic [31:0] post [2];
    logic [3:0]  ad [2];
    bit          en [2];
    bit          wr [2];
    bit          c;
    int          due;
    ad[0] = addra;  ad[1] = addrb;
    en[0] = ena;    en[1] = enb;
    wr[0] = ena && (wea != 0);
    wr[1] = enb && (web != 0);
    for (int p = 0; p < 2; p++) begin
      pre[p]  = (ad[p] < cfg_depth[d]) ? m_mem[d][ad[p]] : 32'h0;
      post[p] = post_word(d, ad[p]);
    end
    for (int p = 0; p < 2; p++)
      if (wr[p] && ad[p] < cfg_depth[d]) m_mem[d][ad[p]] = post[p];
    due = cyc + cfg_lat[d] - 1;
    for (int p = 0; p < 2; p++) begin
      if (!rstb && en[p] && !(wr[p] && cfg_mode[d] == 2)) begin
        s_vld[d][p][due] = 1;
        s_dat[d][p][due] = (wr[p] && cfg_mode[d] == 1) ? pre[p] : post[p];
      end
      if (rstb) begin
        e_vld[d][p]  = 0;
        e_dout[d][p] = '0;
        s_vld[d][p][cyc] = 0;
      end else if (s_vld[d][p][cyc]) begin
        e_vld[d][p]  = 1;
        e_dout[d][p] = s_dat[d][p][cyc];
      end else begin
        e_vld[d][p] = 0;
      end
    end
    c = ena && enb && (addra == addrb) && ((wea & web) != 0);
    if (rstb) begin
      e_flag[d] = 0;
      e_cnt[d]  = 0;
    end else begin
      e_flag[d] = c;
      if (c && e_cnt[d] < cfg_cmax[d]) e_cnt[d]++;
    end
  endtask

  always @(posedge clka) begin
    for (int d = 0; d < 3; d++) model_edge(d);
    if (rstb) model_ok = 1;
    cyc++;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_cnt(int d);
    if (d == 0) return {30'h0, cnt0};
    if (d == 1) return {16'h0, cnt1};
    return {16'h0, cnt2};
  endfunction

  // Compare every DUT output against the model each cycle after first reset.
  always @(negedge clka) begin
    if (model_ok) begin
      for (int d = 0; d < 3; d++) begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("d%0d_vld%s", d, p ? "b" : "a"), {31'h0, d_vld[d][p]}, {31'h0, e_vld[d][p]});
          chk($sformatf("d%0d_dout%s", d, p ? "b" : "a"), d_dout[d][p], e_dout[d][p]);
        end
        chk($sformatf("d%0d_coll_flag", d), {31'h0, d_flag[d]}, {31'h0, e_flag[d]});
        chk($sformatf("d%0d_coll_cnt", d), dut_cnt(d), e_cnt[d]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clka);
    @(negedge clka);
    #1;
  endtask

  task automatic idle();
    ena = 0; enb = 0; wea = '0; web = '0;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [31:0] dt, input logic [3:0] we);
    ena = 1; addra = a; dina = dt; wea = we;
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [31:0] dt, input logic [3:0] we);
    enb = 1; addrb = a; dinb = dt; web = we;
  endtask

  task automatic rd_a(input logic [3:0] a);
    ena = 1; addra = a; wea = '0;
  endtask

  task automatic rd_b(input logic [3:0] a);
    enb = 1; addrb = a; web = '0;
  endtask

  // ---------------- directed stimulus with literal pins ----------------
  initial begin
    logic [3:0] seq [5];
    seq[0] = 4'd5; seq[1] = 4'd7; seq[2] = 4'd9; seq[3] = 4'd3; seq[4] = 4'd2;
    #1;
    rstb = 1; idle(); tick(); tick();
    chk("lit_reset_douta", d_dout[0][0], 32'h0);
    chk("lit_reset_vlda", {31'h0, d_vld[0][0]}, 32'h0);
    chk("lit_reset_cnt", dut_cnt(0), 32'h0);

    rstb = 0; idle(); rd_b(4'd3); tick();
    chk("lit_init_doutb", d_dout[0][1], 32'h0);
    chk("lit_init_vldb", {31'h0, d_vld[0][1]}, 32'h1);

    idle(); wr_a(4'd5, 32'hAABBCCDD, 4'hF); tick();
    idle(); wr_a(4'd5, 32'h11223344, 4'b0101); tick();
    idle(); rd_b(4'd5); tick();
    chk("lit_merge_lat1", d_dout[0][1], 32'hAA22CC44);
    idle(); tick();
    chk("lit_merge_lat2", d_dout[1][1], 32'hAA22CC44);
    chk("lit_merge_lat2_vld", {31'h0, d_vld[1][1]}, 32'h1);

    idle(); wr_a(4'd2, 32'hDEADBEEF, 4'hF); tick();
    chk("lit_wf_douta", d_dout[0][0], 32'hDEADBEEF);
    chk("lit_nc_vlda", {31'h0, d_vld[2][0]}, 32'h0);
    chk("lit_nc_hold", d_dout[2][0], 32'h0);
    idle(); tick();
    chk("lit_rf_douta", d_dout[1][0], 32'h0);

    idle(); wr_a(4'd7, 32'h12345678, 4'hF); rd_b(4'd7); tick();
    chk("lit_xport_doutb", d_dout[0][1], 32'h12345678);

    idle(); wr_a(4'd9, 32'hAAAAAAAA, 4'b0011); wr_b(4'd9, 32'hBBBBBBBB, 4'b0110); tick();
    chk("lit_coll_flag", {31'h0, d_flag[0]}, 32'h1);
    chk("lit_coll_cnt", dut_cnt(0), 32'h1);
    chk("lit_coll_word_a", d_dout[0][0], 32'h00BBAAAA);
    idle(); tick();
    chk("lit_coll_flag_drop", {31'h0, d_flag[0]}, 32'h0);
    rd_b(4'd9); tick();
    chk("lit_coll_store", d_dout[0][1], 32'h00BBAAAA);
    idle(); tick();
    chk("lit_coll_store_prio_b", d_dout[1][1], 32'h00BBBBAA);
    for (int k = 0; k < 4; k++) begin
      idle(); wr_a(4'd9, 32'hAAAAAAAA, 4'b0011); wr_b(4'd9, 32'hBBBBBBBB, 4'b0110); tick();
    end
    idle(); tick();
    chk("lit_cnt_sat", dut_cnt(0), 32'h3);
    chk("lit_cnt_wide", dut_cnt(1), 32'h5);

    idle(); rd_b(4'd7); tick();
    rstb = 1; idle(); rd_b(4'd5); wr_a(4'd3, 32'hCAFEF00D, 4'hF); tick();
    chk("lit_rst_vldb", {31'h0, d_vld[0][1]}, 32'h0);
    chk("lit_rst_doutb", d_dout[0][1], 32'h0);
    rstb = 0; idle(); rd_b(4'd3); tick();
    chk("lit_rst_write_kept", d_dout[0][1], 32'hCAFEF00D);

    idle(); wr_a(4'd13, 32'h00000055, 4'hF); tick();
    idle(); rd_b(4'd13); tick();
    chk("lit_oor_doutb", d_dout[2][1], 32'h0);
    chk("lit_oor_vldb", {31'h0, d_vld[2][1]}, 32'h1);
    chk("lit_inrange_13", d_dout[0][1], 32'h00000055);

    idle(); wr_b(4'd5, 32'h99887766, 4'b1000); rd_a(4'd5); tick();
    chk("lit_xport_b_to_a", d_dout[0][0], 32'h9922CC44);
    for (int k = 0; k < 5; k++) begin
      idle(); rd_a(seq[k]); rd_b(seq[4-k]); tick();
    end
    idle(); rd_a(4'd9); rd_b(4'd9); tick();
    chk("lit_both_read", d_dout[0][0], d_dout[0][1] === 32'h00BBAAAA ? 32'h00BBAAAA : 32'hFFFFFFFF);
    idle(); tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bram_tdp_1ck_be.md
Name: bram_tdp_1ck_be

Overview:
- Parametrised single-clock true dual-port RAM with per-byte write enables and a selectable own-port read-during-write mode (WRITE_FIRST / READ_FIRST / NO_CHANGE).
- Deterministic cross-port collision resolution, read latency of 1 or 2 cycles with a per-port valid strobe, and a saturating collision counter.
- Sits under L2/directory and buffer wrappers in the tile, which need partial-word writes and a read-valid signal instead of fixed-latency assumptions.

Parameters:
- WIDTH, 64, data width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W.
- DEPTH, 512, number of words; AW = clog2(DEPTH), minimum 1.
- READ_LAT, 1, read latency in cycles, 1 or 2 (2 adds an output register).
- WR_MODE, "WRITE_FIRST", own-port data returned on a write: "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
- PRIORITY, "A", port whose byte lanes win when both ports write the same address and lane.
- INIT_ZERO, 1, simulation-time zero fill of the array (1) or none (0).
- CNT_W, 16, collision counter width.

Ports:
- clka  in  1  clock, all logic rising edge.
- rstb  in  1  reset, synchronous, active-high.
- ena  in  1  port A operation enable.
- wea  in  NB  port A byte write enables; any bit set = write, all zero = read.
- addra  in  AW  port A address.
- dina  in  WIDTH  port A write data.
- douta  out  WIDTH  port A read data.
- vlda  out  1  port A read data valid.
- enb, web, addrb, dinb, doutb, vldb  as port A, for port B.
- coll_flag  out  1  one-cycle pulse on a same-lane write/write collision.
- coll_cnt  out  CNT_W  saturating count of write/write collisions.

Behaviour:
- Reset:
  - rstb=1 at an edge sets douta, doutb, vlda, vldb, coll_flag and coll_cnt to 0, and clears the READ_LAT=2 pipeline stage.
  - Array contents are not affected. Writes issued in the reset cycle still update the array.
  - Reads issued in the reset cycle produce no vld.
- Operation issue: a port issues an operation at edge T when enX=1. Writes update only the byte lanes with weX[i]=1.
- Read timing: a read issued at T yields doutX and vldX=1 at T+READ_LAT. vld is high for exactly one cycle per operation. Back-to-back issues give back-to-back results at full throughput.
- Hold: doutX holds its last value whenever vldX=0.
- Own-port write return:
  - WRITE_FIRST: returns the merged post-write word (new lanes where we=1, old lanes elsewhere), with vld.
  - READ_FIRST: returns the pre-write word, with vld.
  - NO_CHANGE: doutX holds and vldX stays 0.
- Cross-port, same cycle, same address, both enabled:
  - Write on X, read on Y: Y returns the post-write merged word (inter-port write-first), independent of WR_MODE.
  - Both write: lanes written by only one port take that port's data; lanes written by both take PRIORITY's data. Each port's own-port return follows WR_MODE, using the final resolved word.
  - Both read: both return the same stored word.
- Collision:
  - Counted only when both ports write the same address with (wea & web) != 0. Read/write overlaps are not collisions.
  - coll_flag pulses at T+1; coll_cnt increments at T+1 and saturates at all ones.
- Out-of-range addresses (DEPTH not a power of two): writes are dropped; reads return 0 with vld.
- READ_LAT=2: both stages advance every cycle, with no stall input. The second stage captures data only when the first stage is valid.

Test Plan:
- Reset/idle (WIDTH=32, DEPTH=16, READ_LAT=1): assert rstb 2 cycles -> douta=doutb=0, vlda=vldb=0, coll_cnt=0. Read addr 3 with INIT_ZERO -> doutb=0x00000000 with vldb=1 one cycle later.
- Byte write merge: A writes 0xAABBCCDD to addr 5 with wea=4'hF, then 0x11223344 with wea=4'b0101; B reads addr 5 -> 0xAA22CC44, vldb at T+1. Repeat with READ_LAT=2 -> data at T+2.
- Own-port modes: addr 2 holds 0x0; A writes 0xDEADBEEF. WRITE_FIRST -> douta=0xDEADBEEF, vlda=1. READ_FIRST -> douta=0x0, vlda=1. NO_CHANGE -> douta holds, vlda=0.
- Cross-port read: A writes 0x12345678 to addr 7 while B reads addr 7 in the same cycle -> doutb=0x12345678 at T+1.
- Write/write collision (PRIORITY="A"): A writes 0xAAAAAAAA with wea=4'b0011 and B writes 0xBBBBBBBB with web=4'b0110, both to addr 9 -> array holds 0x00BBAAAA. coll_flag pulses at T+1, coll_cnt=1. With CNT_W=2, four more collisions -> coll_cnt=3 (saturated).
- Reset mid-read: B issues a read at T and rstb=1 at T -> vldb=0 and doutb=0 at T+1. A write issued at T is still visible on a later read.
